// File: rtl/mem_pkg.sv
// Shared encodings for the load/store alignment unit: access sizes, FSM states
// and the alignment helpers used by the sequencer.
package mem_pkg;

  localparam logic [1:0] SIZE_WORD    = 2'b00;
  localparam logic [1:0] SIZE_BYTE    = 2'b01;
  localparam logic [1:0] SIZE_HALF    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } state_e;

  // Illegal sizes never reach BUSY, so their alignment value does not matter.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic ok;
    case (size)
      SIZE_BYTE: ok = 1'b1;
      SIZE_HALF: ok = ~addr_lo[0];
      SIZE_WORD: ok = (addr_lo == 2'b00);
      default:   ok = 1'b1;
    endcase
    return ok;
  endfunction

  // Index of the final BUSY beat: 0 for a single access, N-1 for byte splitting.
  function automatic logic [1:0] last_beat(input logic [1:0] size, input logic aligned);
    logic [1:0] last;
    if (aligned) begin
      last = 2'd0;
    end else begin
      case (size)
        SIZE_HALF: last = 2'd1;
        SIZE_WORD: last = 2'd3;
        default:   last = 2'd0;
      endcase
    end
    return last;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load extension: selects the low 8/16/32 bits of the raw load
// data and zero- or sign-extends them to the full data width.
module load_extend
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [1:0]            size,
  input  logic                  is_unsigned,
  input  logic [DATA_WIDTH-1:0] raw,
  output logic [DATA_WIDTH-1:0] result
);

  logic fill_b_s;
  logic fill_h_s;

  assign fill_b_s = ~is_unsigned & raw[7];
  assign fill_h_s = ~is_unsigned & raw[15];

  // Width select and extension; word loads pass through untouched.
  always_comb begin
    result = {DATA_WIDTH{1'b0}};
    case (size)
      SIZE_BYTE: result = {{(DATA_WIDTH-8){fill_b_s}}, raw[7:0]};
      SIZE_HALF: result = {{(DATA_WIDTH-16){fill_h_s}}, raw[15:0]};
      SIZE_WORD: result = raw;
      default:   result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/mem_align_unit.sv
// Load/store alignment unit: accepts one access at a time, splits misaligned
// half/word accesses into byte beats and returns extended load data.
module mem_align_unit
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     mem_we,
  output logic [1:0]               mem_dataType,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  state_e                   state_q;
  logic                     we_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic                     mis_q;
  logic [1:0]               cnt_q;
  logic [1:0]               last_q;
  logic [DATA_WIDTH-1:0]    raw_q;

  logic [DATA_WIDTH-1:0]    raw_d;
  logic [7:0]               wbyte_s;
  logic [DATA_WIDTH-1:0]    ext_s;
  logic                     busy_s;
  logic                     resp_s;
  logic                     err_s;

  assign busy_s = (state_q == BUSY);
  assign resp_s = (state_q == RESP);
  assign err_s  = (size_q == SIZE_ILLEGAL);

  // Next load result: whole word when aligned, else byte k into lane k.
  always_comb begin
    raw_d = raw_q;
    if (!mis_q) begin
      raw_d = mem_rdata;
    end else begin
      case (cnt_q)
        2'd0:    raw_d[7:0]   = mem_rdata[7:0];
        2'd1:    raw_d[15:8]  = mem_rdata[7:0];
        2'd2:    raw_d[23:16] = mem_rdata[7:0];
        2'd3:    raw_d[31:24] = mem_rdata[7:0];
        default: raw_d        = raw_q;
      endcase
    end
  end

  // Store byte for the current misaligned beat.
  always_comb begin
    wbyte_s = 8'h00;
    case (cnt_q)
      2'd0:    wbyte_s = wdata_q[7:0];
      2'd1:    wbyte_s = wdata_q[15:8];
      2'd2:    wbyte_s = wdata_q[23:16];
      2'd3:    wbyte_s = wdata_q[31:24];
      default: wbyte_s = 8'h00;
    endcase
  end

  // Sequencer FSM with request capture, beat counter and load result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SIZE_WORD;
      uns_q   <= 1'b0;
      addr_q  <= {ADDRESS_WIDTH{1'b0}};
      wdata_q <= {DATA_WIDTH{1'b0}};
      mis_q   <= 1'b0;
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      raw_q   <= {DATA_WIDTH{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            mis_q   <= ~is_aligned(req_size, req_addr[1:0]);
            last_q  <= last_beat(req_size, is_aligned(req_size, req_addr[1:0]));
            cnt_q   <= 2'd0;
            raw_q   <= {DATA_WIDTH{1'b0}};
            state_q <= (req_size == SIZE_ILLEGAL) ? RESP : BUSY;
          end
        end
        BUSY: begin
          if (!we_q) begin
            raw_q <= raw_d;
          end
          if (cnt_q == last_q) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          cnt_q   <= 2'd0;
          state_q <= IDLE;
        end
        default: begin
          cnt_q   <= 2'd0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  load_extend #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_extend (
    .size       (size_q),
    .is_unsigned(uns_q),
    .raw        (raw_q),
    .result     (ext_s)
  );

  assign req_ready    = (state_q == IDLE);
  assign mem_we       = busy_s & we_q;
  assign mem_dataType = busy_s ? (mis_q ? SIZE_BYTE : size_q) : 2'b00;
  assign mem_addr     = busy_s ? (addr_q + {{(ADDRESS_WIDTH-2){1'b0}}, cnt_q})
                               : {ADDRESS_WIDTH{1'b0}};
  assign mem_wdata    = busy_s ? (mis_q ? {{(DATA_WIDTH-8){1'b0}}, wbyte_s} : wdata_q)
                               : {DATA_WIDTH{1'b0}};
  assign resp_valid   = resp_s;
  assign resp_err     = resp_s & err_s;
  assign resp_rdata   = (resp_s && !we_q && !err_s) ? ext_s : {DATA_WIDTH{1'b0}};

endmodule

// File: doc/mem_align_unit.md
MEM_ALIGN_UNIT -- requirements
Module: mem_align_unit

Interface
REQ-001 SHALL have parameters: ADDRESS_WIDTH, 32, byte address width; DATA_WIDTH, 32, data word width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  access request.
- req_ready  out  1  unit can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 byte, 10 half, 11 illegal.
- req_unsigned  in  1  zero-extend load (LBU/LHU).
- req_addr  in  ADDRESS_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  store data, LSB-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_err  out  1  illegal size, valid with resp_valid.
- resp_rdata  out  DATA_WIDTH  extended load data.
- mem_we  out  1  data RAM write enable.
- mem_dataType  out  2  data RAM access size, same encoding as req_size.
- mem_addr  out  ADDRESS_WIDTH  data RAM address.
- mem_wdata  out  DATA_WIDTH  data RAM write data.
- mem_rdata  in  DATA_WIDTH  data RAM combinational read data.

Function
REQ-003 SHALL use FSM states IDLE, BUSY, RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 SHALL accept on req_valid && req_ready and register we, size, unsigned, addr, wdata; inputs are ignored after acceptance.
REQ-005 SHALL classify as aligned when the access is a byte, a half with addr[0]=0, or a word with addr[1:0]=00; otherwise it is misaligned.
REQ-006 Aligned: SHALL spend exactly 1 BUSY cycle driving mem_dataType=req_size, mem_addr=addr, and mem_wdata=wdata.
REQ-007 Misaligned: SHALL spend N BUSY cycles (N=4 word, 2 half), with cycle k driving mem_dataType=01, mem_addr=addr+k, mem_wdata[7:0]=wdata byte k, and other bits 0.
REQ-008 mem_addr SHALL wrap modulo 2**ADDRESS_WIDTH.
REQ-009 mem_we SHALL equal (state==BUSY && registered we), decoded combinationally from the state register.
REQ-010 Load: SHALL capture mem_rdata at the end of each BUSY cycle; a misaligned access SHALL take byte k from mem_rdata[7:0] into result byte k.
REQ-011 Load result: SHALL take the low 8/16/32 bits and zero-extend if req_unsigned=1, else sign-extend; req_unsigned SHALL be ignored for word.
REQ-012 After the last BUSY cycle: SHALL enter RESP for one cycle with resp_valid=1, then return to IDLE.
REQ-013 Latency: resp_valid SHALL be asserted N+1 cycles after the accept edge (N=1 aligned).
REQ-014 Store: SHALL drive resp_rdata=0.
REQ-015 req_size=11: SHALL skip BUSY, issue no memory access, and in RESP drive resp_err=1 and resp_rdata=0.
REQ-016 Outside RESP, resp_valid, resp_err and resp_rdata SHALL be 0.
REQ-017 Outside BUSY, mem_we, mem_addr, mem_wdata and mem_dataType SHALL be 0.
REQ-018 A request presented during BUSY or RESP SHALL be held off via req_ready=0 and not lost; it is accepted once the unit returns to IDLE.

Reset
REQ-019 rst_n low SHALL immediately force state=IDLE, byte counter=0, and result register=0.
REQ-020 During reset, req_ready=1 and every other output SHALL be 0.
REQ-021 Reset mid-access SHALL abandon the access: remaining bytes are not written and no resp_valid is produced.

Structure
REQ-022 A shared package mem_pkg SHALL hold the size encodings (SIZE_WORD, SIZE_BYTE, SIZE_HALF, SIZE_ILLEGAL) and the FSM state enum.
REQ-023 Load extension SHALL be a combinational sub-module load_extend (inputs: size, unsigned, raw data; output: 32-bit result).
REQ-024 The byte counter SHALL be 2 bits wide.

Verification
REQ-025 Aligned round trip: store word 0xDEADBEEF @0x1000, then load word @0x1000 -> one BUSY cycle each, resp_valid 2 cycles after accept, resp_rdata=0xDEADBEEF.
REQ-026 Misaligned word load @0x1001 with bytes 0x11, 0x22, 0x33, 0x44 at 0x1001..0x1004 -> 4 byte reads at 0x1001..0x1004, resp_rdata=0x44332211, resp_valid 5 cycles after accept.
REQ-027 Byte 0x80 @0x1003: LB -> 0xFFFFFF80; LBU -> 0x00000080; misaligned LH @0x1003 with 0x1004=0x9A -> 0xFFFF9A80.
REQ-028 Misaligned half store 0xA5C3 @0x1003 -> byte writes 0x1003=0xC3 then 0x1004=0xA5; 0x1002 and 0x1005 unchanged.
REQ-029 req_size=11 -> mem_we stays 0, resp_valid=1 with resp_err=1 one cycle after accept.
REQ-030 rst_n low during the 3rd BUSY cycle of a misaligned word store @0x1001 -> mem_we=0 in the same cycle, 0x1003/0x1004 unchanged, no resp_valid, req_ready=1 after release.
